// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: instruction-memory port, redirect/halt controls and
// the IF/ID handshake. The fetch unit takes the master side; the memory and
// the decode stage together form the slave side.
interface instr_fetch_if;
    logic [13:0] imem_pc;
    logic [31:0] imem_ir;
    logic        redirect_valid;
    logic [13:0] redirect_pc;
    logic        halt;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [13:0] id_pc;

    modport master (
        output imem_pc,
        input  imem_ir,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output id_valid,
        input  id_ready,
        output id_ir,
        output id_pc
    );

    modport slave (
        input  imem_pc,
        output imem_ir,
        output redirect_valid,
        output redirect_pc,
        input  halt,
        input  id_valid,
        output id_ready,
        input  id_ir,
        input  id_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Drives a word address to a combinational instruction memory and presents
// the returned word to decode through a valid/ready slot. Redirects (taken
// branches/jumps) win over everything and cost one bubble; halt stops fetch
// until the next redirect or reset.
// Optional feature: define INSTR_FETCH_COUNT_EN to add the 32-bit
// instr_count output, counting IF/ID handshakes.
module instr_fetch #(
    parameter logic [13:0] RESET_PC = 14'd0,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    instr_fetch_if.master bus
`ifdef INSTR_FETCH_COUNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]  r_state;
    logic [13:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_ir;
    logic [13:0] r_id_pc;

    logic        w_slot_free;
    logic        w_fetch;
    logic        w_handshake;

    // The output slot can accept a new word when empty or being drained now.
    assign w_slot_free = !r_id_valid || bus.id_ready;
    // A fetch is captured only in FETCH, with a free slot and no redirect.
    assign w_fetch     = (r_state == S_FETCH) && w_slot_free && !bus.redirect_valid;
    // Decode consumes the presented word on this edge.
    assign w_handshake = r_id_valid && bus.id_ready;

    assign bus.imem_pc  = r_pc;
    assign bus.id_valid = r_id_valid;
    assign bus.id_ir    = r_id_ir;
    assign bus.id_pc    = r_id_pc;

    // Control FSM: BOOT idles one cycle, redirect always lands in FETCH,
    // halt parks in HALTED until the next redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else if (bus.redirect_valid) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_BOOT:   r_state <= S_FETCH;
                S_FETCH:  r_state <= bus.halt ? S_HALTED : S_FETCH;
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_BOOT;
            endcase
        end
    end

    // Program counter: load redirect target, else advance on each captured
    // fetch; the 14-bit add wraps 16383 -> 0 silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc <= bus.redirect_pc;
        end else if (w_fetch) begin
            r_pc <= r_pc + 14'd1;
        end
    end

    // IF/ID slot: flush on redirect, load on fetch, empty when drained,
    // otherwise hold (stall). An empty slot always carries the bubble word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_id_ir    <= NOP_WORD;
            r_id_pc    <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_id_valid <= 1'b0;
            r_id_ir    <= NOP_WORD;
        end else if (w_fetch) begin
            r_id_valid <= 1'b1;
            r_id_ir    <= bus.imem_ir;
            r_id_pc    <= r_pc;
        end else if (bus.id_ready) begin
            r_id_valid <= 1'b0;
            r_id_ir    <= NOP_WORD;
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    logic [31:0] r_instr_count;

    // Count every word handed to decode; free-running 32-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_count <= 32'd0;
        end else if (w_handshake) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    logic w_unused;
    assign w_unused = w_handshake;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected (pc, word) pairs,
// a negedge monitor pops and compares on every IF/ID handshake. A second
// instance with RESET_PC=16382 checks pc wrap under free-running fetch.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_if bus();
    instr_fetch_if bus2();

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return 32'h1000_0000 | {18'd0, a};
    endfunction

    assign bus.imem_ir  = mem_word(bus.imem_pc);
    assign bus2.imem_ir = mem_word(bus2.imem_pc);
    assign bus2.id_ready       = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 14'd0;
    assign bus2.halt           = 1'b0;

`ifdef INSTR_FETCH_COUNT_EN
    logic [31:0] cnt;
    logic [31:0] cnt2;
`endif

    instr_fetch #(.RESET_PC(14'd0), .NOP_WORD(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef INSTR_FETCH_COUNT_EN
        ,
        .instr_count(cnt)
`endif
    );

    instr_fetch #(.RESET_PC(14'd16382), .NOP_WORD(NOP)) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
`ifdef INSTR_FETCH_COUNT_EN
        ,
        .instr_count(cnt2)
`endif
    );

    // Scoreboard
    logic [13:0] exp_pc_q[$];
    logic [31:0] exp_ir_q[$];

    task automatic push(input logic [13:0] p, input logic [31:0] w);
        exp_pc_q.push_back(p);
        exp_ir_q.push_back(w);
    endtask

    // Wrap-instance expectations
    logic [13:0] exp2_pc [4];
    logic [31:0] exp2_ir [4];
    int n2 = 0;
    initial begin
        exp2_pc[0] = 14'd16382; exp2_ir[0] = 32'h1000_3FFE;
        exp2_pc[1] = 14'd16383; exp2_ir[1] = 32'h1000_3FFF;
        exp2_pc[2] = 14'd0;     exp2_ir[2] = 32'h1000_0000;
        exp2_pc[3] = 14'd1;     exp2_ir[3] = 32'h1000_0001;
    end

    // Monitor: compare on each handshake; empty slot must carry the bubble
    always @(negedge clk) begin
        logic [13:0] ep;
        logic [31:0] ew;
        if (!bus.id_valid) begin
            n_tests++;
            if (bus.id_ir !== NOP) begin
                n_fail++;
                $display("FAIL bubble_word actual=%h required=%h", bus.id_ir, NOP);
            end
        end
        if (bus.id_valid && bus.id_ready) begin
            n_tests++;
            if (exp_pc_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word actual pc=%0d ir=%h required=none", bus.id_pc, bus.id_ir);
            end else begin
                ep = exp_pc_q.pop_front();
                ew = exp_ir_q.pop_front();
                if (bus.id_pc !== ep || bus.id_ir !== ew) begin
                    n_fail++;
                    $display("FAIL sb_word actual pc=%0d ir=%h required pc=%0d ir=%h",
                             bus.id_pc, bus.id_ir, ep, ew);
                end
            end
        end
        if (bus2.id_valid && bus2.id_ready && n2 < 4) begin
            n_tests++;
            if (bus2.id_pc !== exp2_pc[n2] || bus2.id_ir !== exp2_ir[n2]) begin
                n_fail++;
                $display("FAIL wrap_word[%0d] actual pc=%0d ir=%h required pc=%0d ir=%h",
                         n2, bus2.id_pc, bus2.id_ir, exp2_pc[n2], exp2_ir[n2]);
            end
            n2++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 14'd0;
        bus.halt           = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_ir", bus.id_ir, NOP);
        chk("rst_idpc", {18'd0, bus.id_pc}, 32'd0);
        chk("rst_imem_pc", {18'd0, bus.imem_pc}, 32'd0);
        chk("rst_pc2", {18'd0, bus2.imem_pc}, 32'd16382);
`ifdef INSTR_FETCH_COUNT_EN
        chk("rst_count", cnt, 32'd0);
`endif

        // Free-running words A..D at pc 0..3
        push(14'd0, 32'h1000_0000);
        push(14'd1, 32'h1000_0001);
        push(14'd2, 32'h1000_0002);
        push(14'd3, 32'h1000_0003);
        tick();
        rst = 1'b0;
        tick();
        chk("boot_no_valid", {31'd0, bus.id_valid}, 32'd0);
        tick();
        chk("first_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("first_pc", {18'd0, bus.id_pc}, 32'd0);
        tick();
        chk("second_pc", {18'd0, bus.id_pc}, 32'd1);
        tick();
        chk("third_pc", {18'd0, bus.id_pc}, 32'd2);

        // Three stall cycles on word 2
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_idpc", {18'd0, bus.id_pc}, 32'd2);
            chk("stall_ir", bus.id_ir, 32'h1000_0002);
            chk("stall_pc", {18'd0, bus.imem_pc}, 32'd3);
            chk("stall_valid", {31'd0, bus.id_valid}, 32'd1);
        end
        bus.id_ready = 1'b1;
        tick();
        chk("after_stall_pc", {18'd0, bus.id_pc}, 32'd3);
        tick();
        chk("next_pc4", {18'd0, bus.id_pc}, 32'd4);

        // Redirect to 100 while stalled on word 4 (word 4 is dropped)
        bus.id_ready = 1'b0;
        tick();
        chk("hold_pc4", {18'd0, bus.id_pc}, 32'd4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 14'd100;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_bubble_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("redir_bubble_ir", bus.id_ir, NOP);
        chk("redir_pc", {18'd0, bus.imem_pc}, 32'd100);
        tick();
        chk("redir_word_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("redir_word_pc", {18'd0, bus.id_pc}, 32'd100);
        chk("redir_word_ir", bus.id_ir, 32'h1000_0064);

        // Word 100 is consumed as a redirect to 4 arrives
        push(14'd100, 32'h1000_0064);
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 14'd4;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir4_bubble", {31'd0, bus.id_valid}, 32'd0);
        push(14'd4, 32'h1000_0004);
        push(14'd5, 32'h1000_0005);
        tick();
        chk("pc4_word", {18'd0, bus.id_pc}, 32'd4);

        // One-cycle halt with pc=5: word 5 still fetched, then nothing
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("halt_word5", {18'd0, bus.id_pc}, 32'd5);
        chk("halt_word5_valid", {31'd0, bus.id_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halted_valid", {31'd0, bus.id_valid}, 32'd0);
            chk("halted_pc", {18'd0, bus.imem_pc}, 32'd6);
        end

        // Resume by redirect to 0; hold word 0 stalled
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 14'd0;
        tick();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0;
        chk("resume_bubble", {31'd0, bus.id_valid}, 32'd0);
        tick();
        chk("resume_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("resume_pc", {18'd0, bus.id_pc}, 32'd0);

        // Reset mid-stall discards the pending word
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("midrst_ir", bus.id_ir, NOP);
        chk("midrst_pc", {18'd0, bus.imem_pc}, 32'd0);
        chk("sb_drained", exp_pc_q.size(), 32'd0);
`ifdef INSTR_FETCH_COUNT_EN
        chk("midrst_count", cnt, 32'd0);
`endif

        // Ten handshakes with two interleaved stall cycles
        for (int i = 0; i < 10; i++) push(i[13:0], 32'h1000_0000 | i);
        bus.id_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("reboot_no_valid", {31'd0, bus.id_valid}, 32'd0);
        tick();
        chk("reboot_pc0", {18'd0, bus.id_pc}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            bus.id_ready = (i == 3 || i == 7) ? 1'b0 : 1'b1;
            tick();
        end
        bus.id_ready = 1'b0;
        tick();
        chk("after10_pc", {18'd0, bus.id_pc}, 32'd10);
`ifdef INSTR_FETCH_COUNT_EN
        chk("count10", cnt, 32'd10);
`endif
        chk("sb_final_empty", exp_pc_q.size(), 32'd0);
        chk("wrap_seen", n2, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 14'd0, first word address fetched after reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, bubble word driven on id_ir when invalid.
REQ-003 SHALL have ports: clk  input  1  rising-edge clock.
REQ-004 SHALL have: rst  input  1  reset, asynchronous, active-high (one clock; polarity and synchronicity fixed).
REQ-005 SHALL have: imem_pc  output  14  word address to instruction memory; read data returns combinationally in the same cycle.
REQ-006 SHALL have: imem_ir  input  32  instruction word at imem_pc.
REQ-007 SHALL have: redirect_valid  input  1  branch/jump taken; redirect_pc  input  14  its target.
REQ-008 SHALL have: halt  input  1  stop fetching after the current cycle.
REQ-009 SHALL have: id_valid  output  1; id_ready  input  1; id_ir  output  32; id_pc  output  14, the IF/ID handshake.

Function
REQ-010 SHALL implement FSM states BOOT, FETCH, HALTED.
- BOOT: entered on reset; one cycle, no fetch; then FETCH.
REQ-011 SHALL hold a 14-bit pc register; imem_pc = pc in all states.
REQ-012 SHALL capture a fetch in FETCH when the output slot is free (id_valid=0 or id_ready=1).
- id_ir<=imem_ir, id_pc<=pc, id_valid<=1, pc<=pc+1.
REQ-013 SHALL wrap pc from 14'd16383 to 14'd0 with no flag.
REQ-014 SHALL hold id_ir, id_pc, id_valid and pc unchanged while id_valid=1 and id_ready=0 (stall).
REQ-015 SHALL clear id_valid when id_ready=1 and no new fetch occurs in that cycle.
REQ-016 SHALL give redirect_valid priority over stall, halt and fetch in any state.
- Next cycle: pc=redirect_pc, id_valid=0, id_ir=NOP_WORD, state=FETCH.
- The first redirected word appears on id_ir one cycle later (one-bubble penalty).
REQ-017 SHALL go to HALTED when halt=1 and redirect_valid=0.
- The cycle with halt=1 still fetches if the slot is free; pc then freezes.
- A pending id_valid word is still delivered under normal handshake.
REQ-018 SHALL leave HALTED only on redirect_valid=1 or reset; halt deasserting alone SHALL NOT resume.
REQ-019 SHALL drive id_ir=NOP_WORD on every cycle where id_valid=0.

Reset
REQ-020 SHALL, on rst=1 regardless of clk:
- state=BOOT, pc=RESET_PC, id_valid=0, id_ir=NOP_WORD, id_pc=RESET_PC, instr_count=0.
REQ-021 SHALL, on reset asserted mid-stall or mid-redirect, discard all pending words and targets.

Configuration
REQ-022 SHALL, with macro INSTR_FETCH_COUNT_EN defined, add output instr_count (32 bits).
- Increments by 1 on each cycle where id_valid=1 and id_ready=1.
- Wraps 32'hFFFFFFFF to 0.
REQ-023 SHALL, without INSTR_FETCH_COUNT_EN, omit the instr_count port and counter entirely, with no other behavioural change.

Verification
REQ-024 SHALL cover reset, then id_ready=1 constantly with memory words 0..3 = A,B,C,D:
- id_valid first high on the 2nd edge after reset release.
- id_pc sequence 0,1,2,3; id_ir sequence A,B,C,D.
REQ-025 SHALL cover id_ready=0 for 3 cycles while id_pc=2:
- id_ir/id_pc hold at word 2 and pc holds at 3.
- After release, the next word delivered is id_pc=3, with no drop or duplicate.
REQ-026 SHALL cover redirect_valid=1, redirect_pc=14'd100, pulsed while stalled:
- Next cycle id_valid=0 and id_ir=NOP_WORD.
- The following cycle id_pc=100.
REQ-027 SHALL cover RESET_PC=14'd16382 with free-running fetch: id_pc sequence 16382,16383,0,1.
REQ-028 SHALL cover a one-cycle halt=1 at pc=5:
- Word 5 is delivered, then id_valid stays 0 indefinitely.
- redirect_pc=14'd0 resumes with id_pc=0.
REQ-029 SHALL cover INSTR_FETCH_COUNT_EN defined, 10 handshakes with 2 interleaved stall cycles: instr_count=10.
